// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side handshake and FIFO write-port signals shared by the arbiter and its neighbours.
// master drives requests and wfull; slave is the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WSIZE = 8
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_last;
    logic [NREQ*WSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic [WSIZE-1:0]      wdata;
    logic                  winc;
    logic                  wfull;
    logic [GW-1:0]         gnt_id;
    logic                  busy;
    logic                  burst_trunc;

    modport master (
        output req_valid, req_last, req_data, wfull,
        input  req_ready, wdata, winc, gnt_id, busy, burst_trunc
    );

    modport slave (
        input  req_valid, req_last, req_data, wfull,
        output req_ready, wdata, winc, gnt_id, busy, burst_trunc
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin packet arbiter for the async FIFO write port; a grant is held for one packet
// of at most MAXBURST beats.
//   state | meaning
//   IDLE  | no grant; scan requesters from rr_ptr and load gnt_id
//   LOCK  | gnt_id owns the write port until last beat or MAXBURST beats
module fifo_wr_arbiter #(
    parameter int NREQ     = 4,
    parameter int WSIZE    = 8,
    parameter int MAXBURST = 16
) (
    input  logic             wclk,
    input  logic             wrst_n,
    fifo_wr_arbiter_if.slave bus
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAXBURST + 1);

    localparam logic [0:0]    IDLE   = 1'b0;
    localparam logic [0:0]    LOCK   = 1'b1;
    localparam logic [GW-1:0] LASTID = GW'(NREQ - 1);
    localparam logic [CW-1:0] CNTMAX = CW'(MAXBURST - 1);

    logic [0:0]       state;
    logic [GW-1:0]    rr_ptr;
    logic [GW-1:0]    gnt_id;
    logic [CW-1:0]    beat_cnt;
    logic             burst_trunc;

    logic             found;
    logic [GW-1:0]    pick;
    logic [GW-1:0]    jj;
    int               j;
    logic             cur_valid;
    logic             cur_last;
    logic [WSIZE-1:0] cur_data;
    logic             lock;
    logic             accept;
    logic             rel;

    // First valid requester scanning rr_ptr, rr_ptr+1, ... modulo NREQ
    always_comb begin
        found = 1'b0;
        pick  = rr_ptr;
        j     = 0;
        jj    = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            jj = GW'(j);
            if (!found && bus.req_valid[jj]) begin
                found = 1'b1;
                pick  = jj;
            end
        end
    end

    always_comb begin
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        cur_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_id == GW'(i)) begin
                cur_valid = bus.req_valid[i];
                cur_last  = bus.req_last[i];
                cur_data  = bus.req_data[i*WSIZE +: WSIZE];
            end
        end
    end

    assign lock   = (state == LOCK);
    assign accept = lock && cur_valid && !bus.wfull;
    assign rel    = accept && (cur_last || (beat_cnt == CNTMAX));

    assign bus.winc        = accept;
    assign bus.wdata       = lock ? cur_data : '0;
    assign bus.req_ready   = (lock && !bus.wfull) ? (NREQ'(1) << gnt_id) : '0;
    assign bus.gnt_id      = gnt_id;
    assign bus.busy        = lock;
    assign bus.burst_trunc = burst_trunc;

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            gnt_id      <= '0;
            beat_cnt    <= '0;
            burst_trunc <= 1'b0;
        end else begin
            burst_trunc <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt_id   <= pick;
                        beat_cnt <= '0;
                        state    <= LOCK;
                    end
                end
                LOCK: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (rel) begin
                            state       <= IDLE;
                            rr_ptr      <= (gnt_id == LASTID) ? '0 : gnt_id + 1'b1;
                            burst_trunc <= !cur_last;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a cycle table for reset, single packet and round robin,
// then hand-written backpressure, truncation and mid-packet reset sequences.
module tb_fifo_wr_arbiter;
    logic wclk;
    logic wrst_n;

    fifo_wr_arbiter_if #(.NREQ(4), .WSIZE(8)) bus ();

    fifo_wr_arbiter #(.NREQ(4), .WSIZE(8), .MAXBURST(16)) dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .bus    (bus)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    typedef struct {
        logic        rst_n;
        logic [3:0]  valid;
        logic [3:0]  last;
        logic        wfull;
        logic [31:0] data;
        logic [3:0]  e_ready;
        logic        e_winc;
        logic [7:0]  e_wdata;
        logic [1:0]  e_gnt;
        logic        e_busy;
        logic        e_trunc;
    } vec_t;

    vec_t       tv[$];
    logic [7:0] wq[$];
    int         passed = 0;
    int         total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic add(input logic r, input logic [3:0] v, input logic [3:0] l, input logic f,
                       input logic [31:0] d, input logic [3:0] er, input logic ew,
                       input logic [7:0] ed, input logic [1:0] eg, input logic eb,
                       input logic et);
        vec_t t;
        t.rst_n = r; t.valid = v; t.last = l; t.wfull = f; t.data = d;
        t.e_ready = er; t.e_winc = ew; t.e_wdata = ed; t.e_gnt = eg; t.e_busy = eb;
        t.e_trunc = et;
        tv.push_back(t);
    endtask

    // Apply inputs at the falling edge and let combinational outputs settle before sampling
    task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] l,
                         input logic f, input logic [31:0] d);
        @(negedge wclk);
        wrst_n        = r;
        bus.req_valid = v;
        bus.req_last  = l;
        bus.wfull     = f;
        bus.req_data  = d;
        #1;
        if (bus.winc === 1'b1) wq.push_back(bus.wdata);
    endtask

    function automatic logic [31:0] w(input int req, input logic [7:0] v);
        return 32'(v) << (req * 8);
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int ok;
        wrst_n = 1'b0;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.wfull     = 1'b0;
        bus.req_data  = '0;

        // reset held with all requesters valid
        add(0, 4'hF, 4'h0, 0, 32'h0,         4'h0, 0, 8'h00, 2'd0, 0, 0);
        add(0, 4'hF, 4'h0, 0, 32'h0,         4'h0, 0, 8'h00, 2'd0, 0, 0);
        // single packet from req 2
        add(1, 4'h4, 4'h0, 0, 32'h00A10000, 4'h0, 0, 8'h00, 2'd0, 0, 0);
        add(1, 4'h4, 4'h0, 0, 32'h00A10000, 4'h4, 1, 8'hA1, 2'd2, 1, 0);
        add(1, 4'h4, 4'h0, 0, 32'h00B20000, 4'h4, 1, 8'hB2, 2'd2, 1, 0);
        add(1, 4'h4, 4'h4, 0, 32'h00C30000, 4'h4, 1, 8'hC3, 2'd2, 1, 0);
        add(1, 4'h0, 4'h0, 0, 32'h0,         4'h0, 0, 8'h00, 2'd2, 0, 0);
        // reset again, then round robin with 1-word packets
        add(0, 4'hF, 4'hF, 0, 32'h13121110, 4'h0, 0, 8'h00, 2'd2, 0, 0);
        add(1, 4'hF, 4'hF, 0, 32'h13121110, 4'h0, 0, 8'h00, 2'd0, 0, 0);
        add(1, 4'hF, 4'hF, 0, 32'h13121110, 4'h1, 1, 8'h10, 2'd0, 1, 0);
        add(1, 4'hF, 4'hF, 0, 32'h13121110, 4'h0, 0, 8'h00, 2'd0, 0, 0);
        add(1, 4'hF, 4'hF, 0, 32'h13121110, 4'h2, 1, 8'h11, 2'd1, 1, 0);
        add(1, 4'hF, 4'hF, 0, 32'h13121110, 4'h0, 0, 8'h00, 2'd1, 0, 0);
        add(1, 4'hF, 4'hF, 0, 32'h13121110, 4'h4, 1, 8'h12, 2'd2, 1, 0);
        add(1, 4'hF, 4'hF, 0, 32'h13121110, 4'h0, 0, 8'h00, 2'd2, 0, 0);
        add(1, 4'hF, 4'hF, 0, 32'h13121110, 4'h8, 1, 8'h13, 2'd3, 1, 0);
        add(1, 4'hF, 4'hF, 0, 32'h13121110, 4'h0, 0, 8'h00, 2'd3, 0, 0);
        add(1, 4'hF, 4'hF, 0, 32'h13121110, 4'h1, 1, 8'h10, 2'd0, 1, 0);
        add(1, 4'h0, 4'h0, 0, 32'h0,         4'h0, 0, 8'h00, 2'd0, 0, 0);

        drive(0, 4'h0, 4'h0, 0, 32'h0);
        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].rst_n, tv[i].valid, tv[i].last, tv[i].wfull, tv[i].data);
            chk($sformatf("vec%0d", i),
                32'({bus.req_ready, bus.winc, bus.wdata, bus.gnt_id, bus.busy, bus.burst_trunc}),
                32'({tv[i].e_ready, tv[i].e_winc, tv[i].e_wdata, tv[i].e_gnt, tv[i].e_busy,
                     tv[i].e_trunc}));
        end

        // backpressure mid-packet of req 1
        drive(0, 4'h0, 4'h0, 0, 32'h0);
        drive(1, 4'h2, 4'h0, 0, w(1, 8'h40));
        chk("bp_idle_busy", 32'(bus.busy), 32'd0);
        wq.delete();
        for (int k = 0; k < 6; k++) begin
            if (k == 2) begin
                for (int s = 0; s < 5; s++) begin
                    drive(1, 4'h2, 4'h0, 1, w(1, 8'h42));
                    chk("bp_stall", 32'({bus.winc, bus.req_ready, bus.busy}), 32'b000001);
                end
            end
            drive(1, 4'h2, (k == 5) ? 4'h2 : 4'h0, 0, w(1, 8'(8'h40 + k)));
            chk($sformatf("bp_word%0d", k), 32'({bus.winc, bus.req_ready, bus.wdata}),
                32'({1'b1, 4'b0010, 8'(8'h40 + k)}));
        end
        drive(1, 4'h0, 4'h0, 0, 32'h0);
        chk("bp_after", 32'({bus.busy, bus.gnt_id}), 32'({1'b0, 2'd1}));
        chk("bp_count", wq.size(), 32'd6);
        for (int k = 0; k < wq.size() && k < 6; k++)
            chk($sformatf("bp_fifo%0d", k), 32'(wq[k]), 32'(8'h40 + k));

        // truncation, only req 0 requesting
        drive(0, 4'h0, 4'h0, 0, 32'h0);
        drive(1, 4'h1, 4'h0, 0, w(0, 8'h60));
        ok = 0;
        for (int k = 0; k < 16; k++) begin
            drive(1, 4'h1, 4'h0, 0, w(0, 8'(8'h60 + k)));
            if (bus.winc === 1'b1 && bus.burst_trunc === 1'b0 && bus.wdata === 8'(8'h60 + k))
                ok++;
        end
        chk("trunc_accepts", ok, 32'd16);
        drive(1, 4'h1, 4'h0, 0, w(0, 8'h70));
        chk("trunc_pulse", 32'({bus.busy, bus.burst_trunc, bus.winc}), 32'b010);
        drive(1, 4'h1, 4'h0, 0, w(0, 8'h70));
        chk("trunc_regrant0", 32'({bus.busy, bus.burst_trunc, bus.gnt_id, bus.winc, bus.wdata}),
            32'({1'b1, 1'b0, 2'd0, 1'b1, 8'h70}));
        drive(1, 4'h1, 4'h1, 0, w(0, 8'h71));
        chk("trunc_last_accept", 32'(bus.winc), 32'd1);
        drive(1, 4'h0, 4'h0, 0, 32'h0);
        chk("trunc_no_pulse_on_last", 32'({bus.busy, bus.burst_trunc}), 32'b00);

        // truncation with req 1 waiting
        drive(0, 4'h0, 4'h0, 0, 32'h0);
        drive(1, 4'h3, 4'h2, 0, w(1, 8'h99) | w(0, 8'h80));
        ok = 0;
        for (int k = 0; k < 16; k++) begin
            drive(1, 4'h3, 4'h2, 0, w(1, 8'h99) | w(0, 8'(8'h80 + k)));
            if (bus.winc === 1'b1 && bus.gnt_id === 2'd0 && bus.wdata === 8'(8'h80 + k)) ok++;
        end
        chk("trunc2_accepts", ok, 32'd16);
        drive(1, 4'h3, 4'h2, 0, w(1, 8'h99) | w(0, 8'h90));
        chk("trunc2_pulse", 32'({bus.busy, bus.burst_trunc}), 32'b01);
        drive(1, 4'h3, 4'h2, 0, w(1, 8'h99) | w(0, 8'h90));
        chk("trunc2_grant1", 32'({bus.gnt_id, bus.burst_trunc, bus.winc, bus.wdata}),
            32'({2'd1, 1'b0, 1'b1, 8'h99}));

        // reset after 2 of 5 words from req 2
        drive(0, 4'h0, 4'h0, 0, 32'h0);
        drive(1, 4'h4, 4'h0, 0, w(2, 8'hC0));
        drive(1, 4'h4, 4'h0, 0, w(2, 8'hC0));
        chk("rst_w0", 32'({bus.winc, bus.wdata}), 32'({1'b1, 8'hC0}));
        drive(1, 4'h4, 4'h0, 0, w(2, 8'hC1));
        chk("rst_w1", 32'({bus.winc, bus.wdata}), 32'({1'b1, 8'hC1}));
        drive(0, 4'h0, 4'h0, 0, w(2, 8'hC2));
        drive(1, 4'h5, 4'h1, 0, w(2, 8'hC2) | w(0, 8'hD0));
        chk("rst_idle", 32'({bus.busy, bus.winc, bus.req_ready}), 32'd0);
        drive(1, 4'h5, 4'h1, 0, w(2, 8'hC2) | w(0, 8'hD0));
        chk("rst_regrant0", 32'({bus.gnt_id, bus.busy, bus.winc, bus.wdata}),
            32'({2'd0, 1'b1, 1'b1, 8'hD0}));
        drive(1, 4'h0, 4'h0, 0, 32'h0);
        chk("rst_release", 32'({bus.busy, bus.burst_trunc}), 32'b00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
